// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM state encoding,
// frame geometry, retry limit and the odd-parity helper.
package ps2_pkg;

    // Transmitter sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RELEASE,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    // Extra attempts after a NACK or timeout when retries are built in.
    localparam int PS2_MAX_RETRY = 2;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester (master) and the PS/2 host
// transmitter (slave): byte request plus the completion report.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       err;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  done,
        input  ack_ok,
        input  err
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output done,
        output ack_ok,
        output err
    );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw kclk/kdata pins plus a kclk
// falling-edge pulse. Shared with the keyboard receiver on the same pins.
// A pin fall produces a fall pulse during the third clk cycle, so logic
// consuming it acts on the third edge after the pin changed.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic kclk_i,
    input  logic kdata_i,
    output logic kclk_s_o,
    output logic kdata_s_o,
    output logic kclk_fall_o
);

    logic [1:0] meta_q;
    logic [1:0] sync_q;
    logic       kclk_prev_q;

    // Bit 0 carries kclk, bit 1 carries kdata; idle lines reset high so
    // reset never manufactures a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q      <= 2'b11;
            sync_q      <= 2'b11;
            kclk_prev_q <= 1'b1;
        end else begin
            meta_q      <= {kdata_i, kclk_i};
            sync_q      <= meta_q;
            kclk_prev_q <= sync_q[0];
        end
    end

    assign kclk_s_o    = sync_q[0];
    assign kdata_s_o   = sync_q[1];
    assign kclk_fall_o = kclk_prev_q & ~sync_q[0];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues the start
// bit, shifts the byte out on device-generated falling edges and collects
// the device ACK. kclk_oe/kdata_oe are open-drain pull-down enables.
// Optional feature macro: PS2_TX_RETRY_EN (retry a failed frame up to
// PS2_MAX_RETRY extra times before reporting the failure).
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  cmd,
    input  logic          kclk,
    input  logic          kdata,
    output logic          kclk_oe,
    output logic          kdata_oe
);

    localparam int SW = PS2_FRAME_BITS - 1;  // stop, parity, 8 data bits
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    BIT_LAST = 4'(PS2_FRAME_BITS - 2);

    ps2_state_e     state_q;
    logic [SW-1:0]  shift_q;
    logic [3:0]     bit_q;
    logic [IW-1:0]  inh_q;
    logic [WW-1:0]  wd_q;
    logic           nack_q;
    logic           kclk_oe_q;
    logic           kdata_oe_q;
    logic           tx_ready_q;
    logic           busy_q;
    logic           done_q;
    logic           ack_ok_q;
    logic           err_q;

`ifdef PS2_TX_RETRY_EN
    logic [1:0]     retry_q;
    logic [7:0]     data_q;
    logic           retry_now;
`endif

    logic           kclk_s;
    logic           kdata_s;
    logic           kclk_fall;
    logic           end_now;
    logic           fail_now;

    ps2_line_sync u_sync (
        .clk         (clk),
        .rst         (rst),
        .kclk_i      (kclk),
        .kdata_i     (kdata),
        .kclk_s_o    (kclk_s),
        .kdata_s_o   (kdata_s),
        .kclk_fall_o (kclk_fall)
    );

    // Decide whether the current attempt ends this cycle: the watchdog has
    // priority over a normal finish once the lines have gone idle.
    always_comb begin
        end_now  = 1'b0;
        fail_now = 1'b0;
        if (state_q != IDLE && state_q != INHIBIT) begin
            if (wd_q == WD_LAST) begin
                end_now  = 1'b1;
                fail_now = 1'b1;
            end else if (state_q == WAIT_IDLE && kclk_s && kdata_s) begin
                end_now  = 1'b1;
                fail_now = nack_q;
            end
        end
    end

`ifdef PS2_TX_RETRY_EN
    assign retry_now = fail_now && (retry_q < 2'(PS2_MAX_RETRY));
`endif

    // Transfer sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_q      <= '0;
            inh_q      <= '0;
            wd_q       <= '0;
            nack_q     <= 1'b0;
            kclk_oe_q  <= 1'b0;
            kdata_oe_q <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_ok_q   <= 1'b0;
            err_q      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= '0;
            data_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (end_now) begin
`ifdef PS2_TX_RETRY_EN
                if (retry_now) begin
                    // Same byte again from a fresh inhibit phase.
                    retry_q    <= retry_q + 2'd1;
                    shift_q    <= {1'b1, ps2_odd_parity(data_q), data_q};
                    bit_q      <= '0;
                    inh_q      <= '0;
                    nack_q     <= 1'b0;
                    kclk_oe_q  <= 1'b1;
                    kdata_oe_q <= 1'b0;
                    state_q    <= INHIBIT;
                end else
`endif
                begin
                    kclk_oe_q  <= 1'b0;
                    kdata_oe_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    ack_ok_q   <= ~fail_now;
                    err_q      <= fail_now;
                    state_q    <= IDLE;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        kclk_oe_q  <= 1'b0;
                        kdata_oe_q <= 1'b0;
                        if (!tx_ready_q) begin
                            // One quiet cycle after done before accepting.
                            tx_ready_q <= 1'b1;
                        end else if (cmd.tx_valid) begin
                            shift_q    <= {1'b1, ps2_odd_parity(cmd.tx_data), cmd.tx_data};
                            bit_q      <= '0;
                            inh_q      <= '0;
                            nack_q     <= 1'b0;
                            ack_ok_q   <= 1'b0;
                            err_q      <= 1'b0;
                            tx_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            kclk_oe_q  <= 1'b1;
                            state_q    <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
                            data_q     <= cmd.tx_data;
                            retry_q    <= '0;
`endif
                        end
                    end
                    INHIBIT: begin
                        inh_q <= inh_q + IW'(1);
                        // Start bit goes low during the final inhibit cycle.
                        if (inh_q == INH_PRE) begin
                            kdata_oe_q <= 1'b1;
                        end
                        if (inh_q == INH_LAST) begin
                            kclk_oe_q  <= 1'b0;
                            kdata_oe_q <= 1'b1;
                            wd_q       <= '0;
                            state_q    <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        wd_q    <= wd_q + WW'(1);
                        state_q <= SEND;
                    end
                    SEND: begin
                        wd_q <= wd_q + WW'(1);
                        if (kclk_fall) begin
                            kdata_oe_q <= ~shift_q[0];
                            shift_q    <= {1'b0, shift_q[SW-1:1]};
                            if (bit_q == BIT_LAST) begin
                                state_q <= ACK;
                            end else begin
                                bit_q <= bit_q + 4'd1;
                            end
                        end
                    end
                    ACK: begin
                        wd_q <= wd_q + WW'(1);
                        if (kclk_fall) begin
                            nack_q  <= kdata_s;
                            state_q <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        wd_q <= wd_q + WW'(1);
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign kclk_oe      = kclk_oe_q;
    assign kdata_oe     = kdata_oe_q;
    assign cmd.tx_ready = tx_ready_q;
    assign cmd.busy     = busy_q;
    assign cmd.done     = done_q;
    assign cmd.ack_ok   = ack_ok_q;
    assign cmd.err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a behavioural keyboard on the open-drain pins.
// Honours PS2_TX_RETRY_EN when the design is built with it.
module tb_ps2_host_tx;

    localparam int INH  = 50;
    localparam int TMO  = 1000;
    localparam int HALF = 20;   // device clock half-period in clk cycles
`ifdef PS2_TX_RETRY_EN
    localparam int BAD_TRIES = 3;
`else
    localparam int BAD_TRIES = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_host_tx_if cmd_if ();
    logic kclk_oe, kdata_oe;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic kclk_pin, kdata_pin;
    assign kclk_pin  = ~(kclk_oe | dev_clk_low);
    assign kdata_pin = ~(kdata_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd_if),
        .kclk     (kclk_pin),
        .kdata    (kdata_pin),
        .kclk_oe  (kclk_oe),
        .kdata_oe (kdata_oe)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected completion of the transaction in flight.
    logic exp_ack = 1'b0;
    logic exp_err = 1'b0;
    logic exp_tmo = 1'b0;
    int   exp_inh = 1;

    // Keyboard model: 0 = ACK, 1 = NACK, 2 = stop clocking after 4 bits.
    int          dev_mode = 0;
    logic [10:0] dev_frame = '0;
    int          dev_nbits = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (kclk_pin && !kdata_pin && !rst) begin
                repeat (10) @(negedge clk);
                dev_frame    = '0;
                dev_frame[0] = kdata_pin;
                dev_nbits    = 1;
                for (int k = 1; k <= 10; k++) begin
                    if (dev_mode == 2 && k > 4) break;
                    dev_clk_low = 1'b1;
                    repeat (HALF) @(negedge clk);
                    dev_clk_low  = 1'b0;
                    dev_frame[k] = kdata_pin;
                    dev_nbits    = k + 1;
                    repeat (HALF) @(negedge clk);
                end
                if (dev_mode != 2) begin
                    dev_data_low = (dev_mode == 0);
                    repeat (5) @(negedge clk);
                    dev_clk_low = 1'b1;
                    repeat (HALF) @(negedge clk);
                    dev_clk_low = 1'b0;
                    repeat (HALF) @(negedge clk);
                    dev_data_low = 1'b0;
                end
                while (kclk_pin && !kdata_pin) @(negedge clk);
            end
        end
    end

    // Per-cycle checker against the protocol rules.
    int   run = 0;
    int   inh_cnt = 0;
    int   since = 0;
    int   done_cnt = 0;
    logic prev_kclk_oe = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;
    logic last_ack = 1'b0;
    logic last_err = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (cmd_if.busy && !prev_busy) begin
                inh_cnt = 0;
                chk("accept_kclk_oe", kclk_oe, 1'b1);
                chk("accept_ready_low", cmd_if.tx_ready, 1'b0);
            end
            if (kclk_oe && !prev_kclk_oe) inh_cnt++;
            if (kclk_oe) run++;
            if (kclk_oe && kdata_oe) chk("start_bit_cycle", run, INH);
            if (since > 0) since++;
            if (!kclk_oe && prev_kclk_oe) begin
                chk("inhibit_len", run, INH);
                run = 0;
                since = 1;
            end
            if (!cmd_if.busy) chk("idle_released", {kclk_oe, kdata_oe}, 2'b00);
            if (cmd_if.tx_ready) chk("ready_only_idle", cmd_if.busy, 1'b0);
            if (rst) begin
                last_ack = 1'b0;
                last_err = 1'b0;
            end else if (cmd_if.done) begin
                chk("done_width", prev_done, 1'b0);
                chk("done_ack_ok", cmd_if.ack_ok, exp_ack);
                chk("done_err", cmd_if.err, exp_err);
                chk("inhibit_phases", inh_cnt, exp_inh);
                if (exp_tmo) chk("timeout_latency", (since >= TMO && since <= TMO + 1), 1'b1);
                last_ack = exp_ack;
                last_err = exp_err;
                done_cnt++;
            end else if (!cmd_if.busy) begin
                chk("result_held", {cmd_if.ack_ok, cmd_if.err}, {last_ack, last_err});
            end
            prev_kclk_oe = kclk_oe;
            prev_busy    = cmd_if.busy;
            prev_done    = cmd_if.done;
        end
    end

    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!cmd_if.tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", cmd_if.tx_ready, 1'b1);
        dev_nbits = 0;
        cmd_if.tx_data  = b;
        cmd_if.tx_valid = 1'b1;
        @(negedge clk);
        cmd_if.tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        int n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done_cnt - base, 1);
    endtask

    task automatic wait_bits(input int nb, input int budget);
        int n = 0;
        while (dev_nbits < nb && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("dev_bits_reached", (dev_nbits >= nb), 1'b1);
    endtask

    int base;

    initial begin
        cmd_if.tx_data  = 8'h00;
        cmd_if.tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_ready", cmd_if.tx_ready, 1'b1);
        chk("rst_busy", cmd_if.busy, 1'b0);
        chk("rst_done", cmd_if.done, 1'b0);
        chk("rst_ack_ok", cmd_if.ack_ok, 1'b0);
        chk("rst_err", cmd_if.err, 1'b0);
        chk("rst_kclk_oe", kclk_oe, 1'b0);
        chk("rst_kdata_oe", kdata_oe, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 0xED, device ACKs.
        dev_mode = 0; exp_ack = 1'b1; exp_err = 1'b0; exp_tmo = 1'b0; exp_inh = 1;
        base = done_cnt;
        send(8'hED);
        wait_done(base, 3000);
        chk("frame_ed_model", dev_frame, model_frame(8'hED));
        chk("frame_ed_literal", dev_frame, 11'h7DA);
        repeat (50) @(negedge clk);
        chk("ed_single_done", done_cnt - base, 1);
        chk("ed_ready_back", cmd_if.tx_ready, 1'b1);
        $display("txn 1: byte ed ack -> ack_ok=%0b err=%0b", cmd_if.ack_ok, cmd_if.err);

        // 0xFF, device NACKs every attempt.
        dev_mode = 1; exp_ack = 1'b0; exp_err = 1'b1; exp_inh = BAD_TRIES;
        base = done_cnt;
        send(8'hFF);
        wait_done(base, 6000);
        chk("frame_ff_model", dev_frame, model_frame(8'hFF));
        chk("frame_ff_literal", dev_frame, 11'h7FE);
        repeat (50) @(negedge clk);
        chk("ff_single_done", done_cnt - base, 1);
        $display("txn 2: byte ff nack -> ack_ok=%0b err=%0b", cmd_if.ack_ok, cmd_if.err);

        // 0xA3 with 0x55 offered while busy.
        dev_mode = 0; exp_ack = 1'b1; exp_err = 1'b0; exp_inh = 1;
        base = done_cnt;
        send(8'hA3);
        wait_bits(3, 1000);
        cmd_if.tx_data  = 8'h55;
        cmd_if.tx_valid = 1'b1;
        repeat (100) @(negedge clk);
        cmd_if.tx_valid = 1'b0;
        wait_done(base, 3000);
        chk("frame_a3_model", dev_frame, model_frame(8'hA3));
        repeat (100) @(negedge clk);
        chk("a3_single_done", done_cnt - base, 1);
        chk("a3_no_second_txn", cmd_if.busy, 1'b0);
        $display("txn 3: byte a3 (55 while busy) -> ack_ok=%0b err=%0b", cmd_if.ack_ok, cmd_if.err);

        // 0x96, device stops clocking after 4 bits.
        dev_mode = 2; exp_ack = 1'b0; exp_err = 1'b1; exp_tmo = 1'b1; exp_inh = BAD_TRIES;
        base = done_cnt;
        send(8'h96);
        wait_done(base, 6000);
        chk("tmo_bits_seen", dev_nbits, 5);
        chk("tmo_partial_frame", dev_frame[4:0], 5'b01100);
        exp_tmo = 1'b0;
        repeat (50) @(negedge clk);
        chk("tmo_single_done", done_cnt - base, 1);
        $display("txn 4: byte 96 stall -> ack_ok=%0b err=%0b", cmd_if.ack_ok, cmd_if.err);

        // 0x3C interrupted by reset during SEND.
        dev_mode = 0; exp_ack = 1'b1; exp_err = 1'b0; exp_inh = 1;
        base = done_cnt;
        send(8'h3C);
        wait_bits(4, 1000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_kclk_oe", kclk_oe, 1'b0);
        chk("mid_rst_kdata_oe", kdata_oe, 1'b0);
        chk("mid_rst_tx_ready", cmd_if.tx_ready, 1'b1);
        chk("mid_rst_done", cmd_if.done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (600) @(negedge clk);
        chk("mid_rst_no_done", done_cnt - base, 0);
        chk("mid_rst_idle_ready", cmd_if.tx_ready, 1'b1);
        $display("txn 5: byte 3c reset mid-send -> busy=%0b done_count=%0d", cmd_if.busy, done_cnt - base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
